plru_repl_ctrl: RTL
===================

# plru_repl_ctrl

Sequencer for the LLC pseudo-LRU replacement state. It holds the tree-PLRU bits for every set and serves one request at a time over a valid/ready channel. A request either records an access (TOUCH), selects and allocates a victim (VICTIM) or clears a set (CLEAR). It sits between the LLC tag/MESI controller and the replacement state, and is the synthesizable counterpart of the package-level PLRU update and victim functions.

## Interface
- N_WAY, 8, associativity; power of two, at least 2; tree has N_WAY-1 bits per set.
- N_SET, 16, number of sets; power of two.
- SW = $clog2(N_SET), WW = $clog2(N_WAY); derived, not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  plru_op_e: 0 TOUCH, 1 VICTIM, 2 CLEAR, 3 illegal.
- req_set  in  SW  target set.
- req_way  in  WW+1  way accessed (TOUCH only); extra MSB allows out-of-range detection.
- req_inv_mask  in  N_WAY  bit i = way i MESI is I (VICTIM only).
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts response.
- rsp_way  out  WW  touched or chosen way; 0 for CLEAR/error.
- rsp_from_inv  out  1  VICTIM chose an invalid way.
- rsp_err  out  1  illegal op or req_way >= N_WAY; no state change.
- stat_touch, stat_victim, stat_inv_victim  out  32 each  counters (see Configuration).

## Operation
- Tree encoding: node 0 is the root; the children of node b are 2b+1 (lower half) and 2b+2 (upper half).
- Bit = 1 means the most recent access was in the upper half.
- Update for way w: walk from the root, MSB of w first; at each node write bit = current bit of w, then descend to the child that bit selects.
- Victim with req_inv_mask != 0: the lowest-index set bit; rsp_from_inv = 1; no tree walk.
- Victim with req_inv_mask == 0: walk from the root; at each node descend opposite to the stored bit (bit 0 goes upper, bit 1 goes lower); the way index is built MSB first.
- After any VICTIM, the tree is updated with the chosen way, which is allocated and becomes MRU.
- TOUCH: update with req_way; rsp_way = req_way[WW-1:0].
- CLEAR: all bits of the set go to 0.
- Error (op 3, or TOUCH with req_way >= N_WAY): no array write, rsp_err = 1, no counter increment.
- FSM states:
  - IDLE: req_ready = 1; on req_valid, capture the request and go to READ.
  - READ: load the set's bits into a working register and go to CALC.
  - CALC: compute the victim and next bits and go to WRITE.
  - WRITE: write back unless error; load the response registers; go to RESP.
  - RESP: rsp_valid = 1; on rsp_ready go to IDLE.
- Only one request is in flight, so there are no read/write hazards between consecutive requests to the same set.

## Timing
- Acceptance at edge 0 (req_valid & req_ready). rsp_valid rises after edge 3. The earliest next acceptance is the edge after the rsp handshake, so throughput is at most 1 per 5 cycles.
- Request inputs are sampled only at acceptance; later changes are ignored.
- Response outputs stay stable while rsp_valid & !rsp_ready.
- Reset values:
  - State is IDLE; req_ready = 1 after reset deasserts.
  - rsp_valid, rsp_way, rsp_from_inv, rsp_err are 0.
  - All PLRU bits in all sets are 0.
  - Counters are 0.
- Reset mid-operation aborts the request: no write, no response.
- With all bits 0 and no invalid way, the victim is way N_WAY-1.

## Configuration
- PLRU_STATS_EN defined: the three counters increment in WRITE for TOUCH, VICTIM, and VICTIM with rsp_from_inv respectively. Counters saturate at 2^32-1.
- PLRU_STATS_EN undefined: no counter flops; the stat outputs are tied to 0.

## Structure
- Add to the shared replacement package:
  - typedef enum plru_op_e;
  - localparam PLRU_BITS = N_WAY-1;
  - pure functions plru_update_bits(bits, way) and plru_victim_way(bits).
- N_WAY comes from the existing line package.
- One sub-module, plru_tree_next: combinational; takes the bits, op, way and inv_mask; outputs the next bits, chosen way and from_inv flag. It is instantiated in CALC's datapath.
- The state array is a register file with N_SET entries, asynchronously cleared.

## Test plan
- Reset, then VICTIM set 3 with mask 0 -> way 7, rsp_from_inv = 0; set 3 bits become 0b1000101 (nodes 0, 2, 6 set).
- Second VICTIM on set 3 with mask 0 -> way 3; third -> way 5; fourth -> way 1.
- VICTIM set 2 with mask 0b00100100 -> way 2, rsp_from_inv = 1; the tree is updated for way 2.
- TOUCH set 5 with ways 7, 6, 5, 4 in order, then VICTIM with mask 0 -> way 3. Then CLEAR set 5 and VICTIM again -> way 7.
- TOUCH with req_way = 8 and op 3 -> rsp_err = 1 and rsp_way = 0; a following VICTIM shows unchanged bits.
- Hold rsp_ready low for 10 cycles -> rsp fields stable and req_ready = 0 throughout. Assert rst in CALC -> no response is produced and set bits read back as 0.

Source files
------------

// File: rtl/plru_repl_ctrl_pkg.sv
// plru_repl_ctrl_pkg: tree-PLRU sizes, op/state types and reference update/victim functions
package plru_repl_ctrl_pkg;
    localparam int N_WAY = 8;
    localparam int N_SET = 16;
    localparam int SW = $clog2(N_SET);
    localparam int WW = $clog2(N_WAY);
    localparam int PLRU_BITS = N_WAY - 1;
    typedef enum logic [1:0] {PLRU_TOUCH, PLRU_VICTIM, PLRU_CLEAR, PLRU_ILLEGAL} plru_op_e;
    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CALC, ST_WRITE, ST_RESP} plru_state_e;
    typedef logic [PLRU_BITS-1:0] plru_bits_t;
    // node n has children 2n+1 (lower half) and 2n+2 (upper half); bit=1 means upper half is MRU
    function automatic plru_bits_t plru_update_bits(plru_bits_t bits, logic [WW-1:0] way);
        plru_bits_t nb = bits;
        int n = 0;
        for (int l = WW - 1; l >= 0; l--) begin
            nb[n[WW-1:0]] = way[l];
            n = 2 * n + (way[l] ? 2 : 1);
        end
        return nb;
    endfunction
    function automatic logic [WW-1:0] plru_victim_way(plru_bits_t bits);
        logic [WW-1:0] w = '0;
        int n = 0;
        for (int l = WW - 1; l >= 0; l--) begin
            w[l] = ~bits[n[WW-1:0]];
            n = 2 * n + (bits[n[WW-1:0]] ? 1 : 2);
        end
        return w;
    endfunction
    function automatic logic [WW-1:0] plru_first_inv(logic [N_WAY-1:0] mask);
        logic [WW-1:0] w = '0;
        for (int i = N_WAY - 1; i >= 0; i--)
            if (mask[i]) w = WW'(i);
        return w;
    endfunction
endpackage

// File: rtl/plru_repl_ctrl_if.sv
// plru_repl_ctrl_if: request/response channel and statistics of the PLRU sequencer
interface plru_repl_ctrl_if;
    import plru_repl_ctrl_pkg::*;
    logic req_valid, req_ready;
    plru_op_e req_op;
    logic [SW-1:0] req_set;
    logic [WW:0] req_way;
    logic [N_WAY-1:0] req_inv_mask;
    logic rsp_valid, rsp_ready;
    logic [WW-1:0] rsp_way;
    logic rsp_from_inv, rsp_err;
    logic [31:0] stat_touch, stat_victim, stat_inv_victim;
    modport master (
        output req_valid, req_op, req_set, req_way, req_inv_mask, rsp_ready,
        input req_ready, rsp_valid, rsp_way, rsp_from_inv, rsp_err, stat_touch, stat_victim, stat_inv_victim
    );
    modport slave (
        input req_valid, req_op, req_set, req_way, req_inv_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_way, rsp_from_inv, rsp_err, stat_touch, stat_victim, stat_inv_victim
    );
endinterface

// File: rtl/plru_tree_next.sv
// plru_tree_next: combinational next-bits, chosen way and invalid-way flag for one PLRU op
module plru_tree_next
    import plru_repl_ctrl_pkg::*;
(
    input  plru_bits_t       bits,
    input  plru_op_e         op,
    input  logic [WW-1:0]    way,
    input  logic [N_WAY-1:0] inv_mask,
    output plru_bits_t       next_bits,
    output logic [WW-1:0]    sel_way,
    output logic             from_inv
);
    always_comb begin
        from_inv = op == PLRU_VICTIM && |inv_mask;
        sel_way = op == PLRU_TOUCH ? way :
                  from_inv ? plru_first_inv(inv_mask) :
                  op == PLRU_VICTIM ? plru_victim_way(bits) : '0;
        next_bits = op == PLRU_CLEAR ? '0 :
                    (op == PLRU_TOUCH || op == PLRU_VICTIM) ? plru_update_bits(bits, sel_way) : bits;
    end
endmodule

// File: rtl/plru_repl_ctrl.sv
// plru_repl_ctrl: one-at-a-time tree-PLRU sequencer over a per-set register file
// PLRU_STATS_EN adds saturating touch/victim/invalid-victim counters.
module plru_repl_ctrl
    import plru_repl_ctrl_pkg::*;
(
    input logic clk,
    input logic rst,
    plru_repl_ctrl_if.slave bus
);
    plru_state_e state, state_n;
    plru_op_e op_q;
    logic [SW-1:0] set_q;
    logic [WW-1:0] way_q, sel_w, sel_q;
    logic [N_WAY-1:0] mask_q;
    plru_bits_t mem [N_SET];
    plru_bits_t bits_q, next_w, next_q;
    logic err_q, inv_w, inv_q, wr;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        bus.req_ready = state == ST_IDLE;
        bus.rsp_valid = state == ST_RESP;
        case (state)
            ST_IDLE:  state_n = bus.req_valid ? ST_READ : ST_IDLE;
            ST_READ:  state_n = ST_CALC;
            ST_CALC:  state_n = ST_WRITE;
            ST_WRITE: state_n = ST_RESP;
            ST_RESP:  state_n = bus.rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_n = ST_IDLE;
        endcase
    end
    plru_tree_next u_next (
        .bits(bits_q), .op(op_q), .way(way_q), .inv_mask(mask_q),
        .next_bits(next_w), .sel_way(sel_w), .from_inv(inv_w)
    );
    assign wr = state == ST_WRITE && !err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op_q <= PLRU_TOUCH;
            set_q <= '0;
            way_q <= '0;
            mask_q <= '0;
            err_q <= 1'b0;
            bits_q <= '0;
            next_q <= '0;
            sel_q <= '0;
            inv_q <= 1'b0;
            bus.rsp_way <= '0;
            bus.rsp_from_inv <= 1'b0;
            bus.rsp_err <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                set_q <= bus.req_set;
                way_q <= bus.req_way[WW-1:0];
                mask_q <= bus.req_inv_mask;
                err_q <= bus.req_op == PLRU_ILLEGAL || (bus.req_op == PLRU_TOUCH && bus.req_way >= (WW+1)'(N_WAY));
            end
            if (state == ST_READ) bits_q <= mem[set_q];
            if (state == ST_CALC) begin
                next_q <= next_w;
                sel_q <= sel_w;
                inv_q <= inv_w;
            end
            if (state == ST_WRITE) begin
                bus.rsp_way <= err_q ? '0 : sel_q;
                bus.rsp_from_inv <= inv_q && !err_q;
                bus.rsp_err <= err_q;
            end
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < N_SET; i++) mem[i] <= '0;
        else if (wr) mem[set_q] <= next_q;
`ifdef PLRU_STATS_EN
    logic [31:0] n_touch, n_victim, n_inv;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            n_touch <= '0;
            n_victim <= '0;
            n_inv <= '0;
        end else if (wr) begin
            if (op_q == PLRU_TOUCH && ~&n_touch) n_touch <= n_touch + 1'b1;
            if (op_q == PLRU_VICTIM && ~&n_victim) n_victim <= n_victim + 1'b1;
            if (op_q == PLRU_VICTIM && inv_q && ~&n_inv) n_inv <= n_inv + 1'b1;
        end
    assign bus.stat_touch = n_touch;
    assign bus.stat_victim = n_victim;
    assign bus.stat_inv_victim = n_inv;
`else
    assign bus.stat_touch = '0;
    assign bus.stat_victim = '0;
    assign bus.stat_inv_victim = '0;
`endif
endmodule
